// File: rtl/cv_clk_en_nco_if.sv
// -----------------------------------------------------------------------------
// cv_clk_en_nco_if
// Bundle of the control/status signals of the 10.7 MHz clock-enable NCO.
//
// Signals
//   inc_i          new NCO increment, taken when inc_load_i is high
//   inc_load_i     one-cycle load strobe for inc_i
//   pause_req_i    level request to halt the enable stream
//   pause_ack_o    high while the stream is halted on a p-edge boundary
//   clk_en_10m7_o  single-cycle 10.7 MHz clock enable
//   phase_o        mirror of the downstream divide-by-3 count
//   en_cnt_o       free-running count of issued enables
//
// Modports
//   master : the controlling side (drives increment and pause request)
//   slave  : the NCO itself
// -----------------------------------------------------------------------------
interface cv_clk_en_nco_if #(
    parameter int ACC_W = 32
);
    logic [ACC_W-1:0] inc_i;
    logic             inc_load_i;
    logic             pause_req_i;
    logic             pause_ack_o;
    logic             clk_en_10m7_o;
    logic [1:0]       phase_o;
    logic [15:0]      en_cnt_o;

    modport master (
        output inc_i,
        output inc_load_i,
        output pause_req_i,
        input  pause_ack_o,
        input  clk_en_10m7_o,
        input  phase_o,
        input  en_cnt_o
    );

    modport slave (
        input  inc_i,
        input  inc_load_i,
        input  pause_req_i,
        output pause_ack_o,
        output clk_en_10m7_o,
        output phase_o,
        output en_cnt_o
    );
endinterface

// File: rtl/cv_clk_en_nco.sv
// -----------------------------------------------------------------------------
// cv_clk_en_nco
// Source end of the 10.7 MHz clock-enable interface. A phase-accumulator NCO
// turns an arbitrary system clock into single-cycle enables; the carry out of
// the accumulator add becomes the (registered) enable. A 2-bit mirror of the
// downstream divide-by-3 counter lets the pause handshake stop the stream
// exactly after a 3.58 MHz p-edge enable, so the downstream divider is always
// frozen in the same phase.
//
// Ports
//   clk_i       system clock
//   reset_n_i   asynchronous, active-low reset
//   bus         cv_clk_en_nco_if.slave: increment load, pause handshake,
//               enable output, phase mirror and enable counter
//
// Parameters
//   ACC_W        accumulator / increment width (>= 8)
//   INC_DEFAULT  increment after reset (10.7386 MHz from a 50 MHz clock)
// -----------------------------------------------------------------------------
module cv_clk_en_nco #(
    parameter int               ACC_W       = 32,
    parameter logic [ACC_W-1:0] INC_DEFAULT = ACC_W'(32'd922441722)
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    cv_clk_en_nco_if.slave  bus
);

    // Largest accepted increment: 2^(ACC_W-1). With this cap the accumulator
    // cannot carry on two consecutive adds, so enables are never adjacent.
    localparam logic [ACC_W-1:0] INC_MAX = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    // Saturate a requested increment to INC_MAX.
    function automatic logic [ACC_W-1:0] clamp_inc(input logic [ACC_W-1:0] value);
        logic [ACC_W-1:0] result;
        if (value > INC_MAX) begin
            result = INC_MAX;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // Downstream divider counts 0,2,1,0,... advancing on every enable.
    function automatic logic [1:0] phase_step(input logic [1:0] phase);
        logic [1:0] result;
        if (phase == 2'd0) begin
            result = 2'd2;
        end else begin
            result = phase - 2'd1;
        end
        return result;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] inc_r;
    logic             clk_en_r;
    logic [1:0]       phase_r;
    logic [15:0]      en_cnt_r;
    logic             pause_ack_r;

    logic [ACC_W:0]   sum_s;
    logic             nco_run_s;
    logic             p_edge_s;
    logic [ACC_W-1:0] acc_nxt_s;
    logic [ACC_W-1:0] inc_nxt_s;
    logic             clk_en_nxt_s;
    logic [1:0]       phase_nxt_s;
    logic [15:0]      en_cnt_nxt_s;
    logic             pause_ack_nxt_s;

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode. A withdrawn request wins over a coincident p-edge so
    // that pause_ack never asserts once the request has been dropped.
    always_comb begin
        state_nxt_s = state_r;
        p_edge_s    = clk_en_r && (phase_r == 2'd0);
        case (state_r)
            ST_RUN: begin
                if (bus.pause_req_i) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!bus.pause_req_i) begin
                    state_nxt_s = ST_RUN;
                end else if (p_edge_s) begin
                    state_nxt_s = ST_PAUSED;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_PAUSED: begin
                if (!bus.pause_req_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PAUSED;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Datapath next values: NCO add, increment load, phase mirror, counter.
    always_comb begin
        sum_s           = {1'b0, acc_r} + {1'b0, inc_r};
        nco_run_s       = (state_r != ST_PAUSED);
        acc_nxt_s       = acc_r;
        clk_en_nxt_s    = 1'b0;
        inc_nxt_s       = inc_r;
        phase_nxt_s     = phase_r;
        en_cnt_nxt_s    = en_cnt_r;
        pause_ack_nxt_s = (state_nxt_s == ST_PAUSED);

        // While paused the accumulator is held so the stream resumes without
        // a phase jump; the carry is simply not produced.
        if (nco_run_s) begin
            acc_nxt_s    = sum_s[ACC_W-1:0];
            clk_en_nxt_s = sum_s[ACC_W];
        end else begin
            acc_nxt_s    = acc_r;
            clk_en_nxt_s = 1'b0;
        end

        // Loads are honoured in every state, independently of the FSM.
        if (bus.inc_load_i) begin
            inc_nxt_s = clamp_inc(bus.inc_i);
        end else begin
            inc_nxt_s = inc_r;
        end

        // Mirror and count on the edge that closes an enable cycle.
        if (clk_en_r) begin
            phase_nxt_s  = phase_step(phase_r);
            en_cnt_nxt_s = en_cnt_r + 16'd1;
        end else begin
            phase_nxt_s  = phase_r;
            en_cnt_nxt_s = en_cnt_r;
        end
    end

    // Datapath and output registers; async reset kills any enable at once.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_r       <= {ACC_W{1'b0}};
            inc_r       <= INC_DEFAULT;
            clk_en_r    <= 1'b0;
            phase_r     <= 2'd0;
            en_cnt_r    <= 16'd0;
            pause_ack_r <= 1'b0;
        end else begin
            acc_r       <= acc_nxt_s;
            inc_r       <= inc_nxt_s;
            clk_en_r    <= clk_en_nxt_s;
            phase_r     <= phase_nxt_s;
            en_cnt_r    <= en_cnt_nxt_s;
            pause_ack_r <= pause_ack_nxt_s;
        end
    end

    assign bus.clk_en_10m7_o = clk_en_r;
    assign bus.phase_o       = phase_r;
    assign bus.en_cnt_o      = en_cnt_r;
    assign bus.pause_ack_o   = pause_ack_r;

endmodule

// File: tb/tb_cv_clk_en_nco.sv
// -----------------------------------------------------------------------------
// tb_cv_clk_en_nco
// Directed bench for cv_clk_en_nco: default cadence, forced 2^30 cadence,
// increment clamp and stop, pause/ack handshake, short pause pulse and
// asynchronous reset from PAUSED and DRAIN.
// -----------------------------------------------------------------------------
module tb_cv_clk_en_nco;

    logic clk;
    logic reset_n;

    cv_clk_en_nco_if #(.ACC_W(32)) bus ();

    cv_clk_en_nco #(.ACC_W(32)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;

    // Bench model of the enable counter and phase mirror, advanced from the
    // observed enable stream, plus cadence statistics.
    int exp_cnt;
    int exp_phase;
    bit prev_en;
    int cyc = 0;
    int last_en_cyc;
    int min_gap;
    int max_gap;
    int adj_err;
    int en_seen = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_cnt     = 0;
        exp_phase   = 0;
        prev_en     = 1'b0;
        last_en_cyc = -1;
    endtask

    task automatic clear_gaps();
        min_gap = 1000000;
        max_gap = 0;
    endtask

    task automatic tick();
        int gap;
        @(posedge clk);
        #1;
        cyc++;
        if (prev_en) begin
            exp_cnt++;
            exp_phase = (exp_phase == 0) ? 2 : exp_phase - 1;
        end
        if (bus.clk_en_10m7_o === 1'b1) begin
            if (prev_en) adj_err++;
            en_seen++;
            if (last_en_cyc >= 0) begin
                gap = cyc - last_en_cyc;
                if (gap < min_gap) min_gap = gap;
                if (gap > max_gap) max_gap = gap;
            end
            last_en_cyc = cyc;
        end
        prev_en = (bus.clk_en_10m7_o === 1'b1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input logic [31:0] value);
        bus.inc_i      = value;
        bus.inc_load_i = 1'b1;
        tick();
        bus.inc_load_i = 1'b0;
    endtask

    task automatic wait_phase1(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus.phase_o === 2'd1 && bus.clk_en_10m7_o === 1'b0) found = 1'b1;
        end
        chk(tag, 64'(found), 64'd1);
    endtask

    task automatic wait_ack(input string tag);
        bit acked;
        acked = 1'b0;
        for (int i = 0; i < 40 && !acked; i++) begin
            tick();
            if (bus.pause_ack_o === 1'b1) acked = 1'b1;
        end
        chk(tag, 64'(acked), 64'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_clk_en"}, 64'(bus.clk_en_10m7_o), 64'd0);
        chk({tag, "_phase"},  64'(bus.phase_o),       64'd0);
        chk({tag, "_en_cnt"}, 64'(bus.en_cnt_o),      64'd0);
        chk({tag, "_ack"},    64'(bus.pause_ack_o),   64'd0);
    endtask

    initial begin
        int start;
        int s0;
        int n_drain;
        int ph_first;
        int ph_second;
        int ack_cnt;
        bit acked;

        reset_n         = 1'b0;
        bus.inc_i       = 32'd0;
        bus.inc_load_i  = 1'b0;
        bus.pause_req_i = 1'b0;
        model_reset();
        clear_gaps();
        adj_err = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");

        // Default increment: 50,000 cycles -> floor(49999*inc/2^32) = 10738.
        @(negedge clk);
        reset_n = 1'b1;
        ticks(50000);
        chk("t2_en_cnt",   64'(bus.en_cnt_o), 64'd10738);
        chk("t2_phase",    64'(bus.phase_o),  64'd2);
        chk("t2_adjacent", 64'(adj_err),      64'd0);
        chk("t2_model",    64'(bus.en_cnt_o), 64'(exp_cnt));

        // inc = 2^30: enable every 4th cycle, 25 per 100 cycles.
        load(32'h4000_0000);
        ticks(8);
        clear_gaps();
        start = exp_cnt;
        ticks(100);
        chk("t1_cnt_100", 64'(bus.en_cnt_o), 64'(start + 25));
        chk("t1_min_gap", 64'(min_gap),      64'd4);
        chk("t1_max_gap", 64'(max_gap),      64'd4);
        chk("t1_phase",   64'(bus.phase_o),  64'(exp_phase));
        chk("t1_model",   64'(bus.en_cnt_o), 64'(exp_cnt));

        // All-ones increment clamps to 2^31: alternate-cycle enables.
        load(32'hFFFF_FFFF);
        ticks(6);
        clear_gaps();
        ticks(20);
        chk("t3_min_gap",  64'(min_gap), 64'd2);
        chk("t3_max_gap",  64'(max_gap), 64'd2);
        chk("t3_adjacent", 64'(adj_err), 64'd0);

        // Zero increment: at most the in-flight enable, then silence.
        load(32'd0);
        tick();
        chk("t3_stop_next", 64'(bus.clk_en_10m7_o), 64'd0);
        s0 = en_seen;
        ticks(50);
        chk("t3_stopped",   64'(en_seen - s0),    64'd0);
        chk("t3_cnt_model", 64'(bus.en_cnt_o),    64'(exp_cnt));

        // Pause requested at phase 1: enables at phase 1 and 0, then PAUSED.
        load(32'h4000_0000);
        wait_phase1("t4_wait_phase1");
        bus.pause_req_i = 1'b1;
        n_drain   = 0;
        ph_first  = 9;
        ph_second = 9;
        acked     = 1'b0;
        for (int i = 0; i < 40 && !acked; i++) begin
            tick();
            if (bus.pause_ack_o === 1'b1) begin
                acked = 1'b1;
            end else if (bus.clk_en_10m7_o === 1'b1) begin
                if (n_drain == 0) ph_first = int'(bus.phase_o);
                else if (n_drain == 1) ph_second = int'(bus.phase_o);
                n_drain++;
            end
        end
        chk("t4_acked",       64'(acked),             64'd1);
        chk("t4_drain_ens",   64'(n_drain),           64'd2);
        chk("t4_first_ph",    64'(ph_first),          64'd1);
        chk("t4_second_ph",   64'(ph_second),         64'd0);
        chk("t4_paused_ph",   64'(bus.phase_o),       64'd2);
        chk("t4_paused_en",   64'(bus.clk_en_10m7_o), 64'd0);
        s0 = en_seen;
        ack_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.pause_ack_o !== 1'b1) ack_cnt++;
        end
        chk("t4_no_en_200", 64'(en_seen - s0), 64'd0);
        chk("t4_ack_held",  64'(ack_cnt),      64'd0);
        chk("t4_ph_held",   64'(bus.phase_o),  64'd2);

        // Release: ack drops on the next edge, enable on the fourth.
        bus.pause_req_i = 1'b0;
        s0 = en_seen;
        tick();
        chk("t4_ack_drop", 64'(bus.pause_ack_o), 64'd0);
        ticks(2);
        chk("t4_quiet_3", 64'(en_seen - s0), 64'd0);
        tick();
        chk("t4_resume_4", 64'(bus.clk_en_10m7_o), 64'd1);
        chk("t4_resume_ph", 64'(bus.phase_o), 64'd2);

        // One-cycle request while draining: back to RUN, cadence unchanged.
        wait_phase1("t5_wait_phase1");
        clear_gaps();
        ack_cnt = 0;
        bus.pause_req_i = 1'b1;
        tick();
        if (bus.pause_ack_o === 1'b1) ack_cnt++;
        bus.pause_req_i = 1'b0;
        s0 = en_seen;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.pause_ack_o === 1'b1) ack_cnt++;
        end
        chk("t5_no_ack",  64'(ack_cnt),       64'd0);
        chk("t5_ens_60",  64'(en_seen - s0),  64'd15);
        chk("t5_min_gap", 64'(min_gap),       64'd4);
        chk("t5_max_gap", 64'(max_gap),       64'd4);
        chk("t5_model",   64'(bus.en_cnt_o),  64'(exp_cnt));

        // Reset while PAUSED: outputs clear at once, default increment back.
        bus.pause_req_i = 1'b1;
        wait_ack("t6_wait_ack");
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_outputs_zero("t6_rst_paused");
        bus.pause_req_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        adj_err = 0;
        ticks(1000);
        chk("t6_cnt_1000a", 64'(bus.en_cnt_o), 64'd214);
        chk("t6_phase_a",   64'(bus.phase_o),  64'd2);

        // Reset while DRAIN.
        wait_phase1("t6_wait_phase1");
        bus.pause_req_i = 1'b1;
        ticks(2);
        chk("t6_in_drain", 64'(bus.pause_ack_o), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_outputs_zero("t6_rst_drain");
        bus.pause_req_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        ticks(1000);
        chk("t6_cnt_1000b", 64'(bus.en_cnt_o), 64'd214);
        chk("t6_adjacent",  64'(adj_err),      64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
